// File: rtl/pet_feeder_dispenser.sv
// Auger pet-feeder controller: counts requested portions out of the chute,
// watches for jams, and enforces a cooldown between feeds.
module pet_feeder_dispenser #(
    parameter int unsigned TIMEOUT  = 1000,
    parameter int unsigned COOLDOWN = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       dispense_req,
    input  logic [2:0] portions,
    input  logic       portion_detect,
    input  logic       clear_fault,
    output logic       motor_on,
    output logic       busy,
    output logic       done,
    output logic       jam_fault,
    output logic [7:0] feed_total
);

    typedef enum logic [1:0] {IDLE, RUN, COOL, FAULT} state_t;

    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);
    localparam logic [7:0]  COOL_LAST    = 8'(COOLDOWN - 1);

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        arm_q, arm_d;
    logic [2:0]  target_q, target_d;
    logic [2:0]  delivered_q, delivered_d;
    logic [15:0] timer_q, timer_d;
    logic [7:0]  cool_q, cool_d;
    logic        done_q, done_d;
    logic [7:0]  total_q, total_d;

    logic        req_edge;
    logic [2:0]  delivered_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_q       <= 1'b0;
            arm_q       <= 1'b0;
            target_q    <= '0;
            delivered_q <= '0;
            timer_q     <= '0;
            cool_q      <= '0;
            done_q      <= 1'b0;
            total_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            arm_q       <= arm_d;
            target_q    <= target_d;
            delivered_q <= delivered_d;
            timer_q     <= timer_d;
            cool_q      <= cool_d;
            done_q      <= done_d;
            total_q     <= total_d;
        end
    end

    // arm_q stays low until dispense_req has been seen low once after reset,
    // so a request already held through reset never counts as an edge.
    assign req_edge      = dispense_req & ~req_q & arm_q;
    assign delivered_inc = delivered_q + 3'd1;

    always_comb begin
        state_d     = state_q;
        req_d       = dispense_req;
        arm_d       = arm_q | ~dispense_req;
        target_d    = target_q;
        delivered_d = delivered_q;
        timer_d     = timer_q;
        cool_d      = cool_q;
        done_d      = 1'b0;
        total_d     = total_q;

        case (state_q)
            IDLE: begin
                if (req_edge && enable) begin
                    if (portions != 3'd0) begin
                        target_d    = portions;
                        delivered_d = '0;
                        timer_d     = '0;
                        state_d     = RUN;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                timer_d = timer_q + 16'd1;
                if (portion_detect) begin
                    delivered_d = delivered_inc;
                    total_d     = total_q + 8'd1;
                    timer_d     = '0;
                end
                // Abort wins; a detect in the timeout cycle beats the fault.
                if (!enable) begin
                    state_d = IDLE;
                end else if (portion_detect && (delivered_inc == target_q)) begin
                    state_d = COOL;
                    done_d  = 1'b1;
                    cool_d  = '0;
                end else if (!portion_detect && (timer_q == TIMEOUT_LAST)) begin
                    state_d = FAULT;
                end
            end
            COOL: begin
                if (cool_q == COOL_LAST) begin
                    state_d = IDLE;
                end else begin
                    cool_d = cool_q + 8'd1;
                end
            end
            FAULT: begin
                if (clear_fault) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign motor_on   = (state_q == RUN);
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign jam_fault  = (state_q == FAULT);
    assign feed_total = total_q;

endmodule

// File: tb/tb_pet_feeder_dispenser.sv
// Scoreboarded bench for the feeder: each expected feed completion queues the
// feed_total value that must be visible when done pulses.
module tb_pet_feeder_dispenser;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       dispense_req;
    logic [2:0] portions;
    logic       portion_detect;
    logic       clear_fault;
    logic       motor_on;
    logic       busy;
    logic       done;
    logic       jam_fault;
    logic [7:0] feed_total;

    int checks   = 0;
    int failures = 0;
    int sb[$];

    pet_feeder_dispenser #(
        .TIMEOUT (50),
        .COOLDOWN(16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .dispense_req  (dispense_req),
        .portions      (portions),
        .portion_detect(portion_detect),
        .clear_fault   (clear_fault),
        .motor_on      (motor_on),
        .busy          (busy),
        .done          (done),
        .jam_fault     (jam_fault),
        .feed_total    (feed_total)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic pulse_detect();
        portion_detect = 1'b1;
        tick();
        portion_detect = 1'b0;
    endtask

    // Done monitor: every done pulse must match a queued expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                int e;
                e = sb.pop_front();
                $display("done observed feed_total=%0d expected=%0d", feed_total, e);
                check("done_total", 32'(feed_total), 32'(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int motor_cnt;
        int n;
        rst            = 1'b1;
        enable         = 1'b0;
        dispense_req   = 1'b0;
        portions       = 3'd0;
        portion_detect = 1'b0;
        clear_fault    = 1'b0;

        // Reset state
        ticks(3);
        check("rst_motor", 32'(motor_on), 32'd0);
        check("rst_busy",  32'(busy),     32'd0);
        check("rst_done",  32'(done),     32'd0);
        check("rst_jam",   32'(jam_fault), 32'd0);
        check("rst_total", 32'(feed_total), 32'd0);
        rst = 1'b0;
        ticks(2);

        // Normal feed: 3 portions, request held for 100 cycles
        enable   = 1'b1;
        portions = 3'd3;
        sb.push_back(3);
        dispense_req = 1'b1;
        tick();
        check("run_entry_motor", 32'(motor_on), 32'd1);
        motor_cnt = 1;
        for (int i = 1; i <= 100; i++) begin
            portion_detect = ((i % 20) == 0) && (i <= 60);
            tick();
            if (motor_on) motor_cnt++;
        end
        portion_detect = 1'b0;
        check("normal_motor_cycles", 32'(motor_cnt), 32'd60);
        check("normal_total", 32'(feed_total), 32'd3);
        check("normal_idle", 32'(busy), 32'd0);
        dispense_req = 1'b0;
        tick();

        // Jam: no detect, TIMEOUT=50
        portions = 3'd2;
        dispense_req = 1'b1;
        tick();
        n = 0;
        while (!jam_fault && n < 100) begin
            tick();
            n++;
        end
        check("jam_latency", 32'(n), 32'd50);
        check("jam_motor", 32'(motor_on), 32'd0);
        check("jam_flag", 32'(jam_fault), 32'd1);
        dispense_req = 1'b0;
        tick();
        dispense_req = 1'b1;
        tick();
        pulse_detect();
        check("jam_req_ignored", 32'(jam_fault), 32'd1);
        check("jam_detect_ignored", 32'(feed_total), 32'd3);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        check("jam_cleared", 32'(jam_fault), 32'd0);
        check("jam_idle", 32'(busy), 32'd0);
        tick();
        check("jam_held_req_no_feed", 32'(busy), 32'd0);
        dispense_req = 1'b0;
        tick();

        // Boundary: detect exactly in the timeout cycle
        portions = 3'd2;
        dispense_req = 1'b1;
        tick();
        ticks(49);
        pulse_detect();
        check("edge_no_fault", 32'(jam_fault), 32'd0);
        check("edge_still_run", 32'(motor_on), 32'd1);
        check("edge_total", 32'(feed_total), 32'd4);
        sb.push_back(5);
        pulse_detect();
        ticks(20);
        dispense_req = 1'b0;
        tick();

        // Boundary: zero portions
        portions = 3'd0;
        sb.push_back(5);
        dispense_req = 1'b1;
        tick();
        check("zero_done", 32'(done), 32'd1);
        check("zero_motor", 32'(motor_on), 32'd0);
        check("zero_busy", 32'(busy), 32'd0);
        tick();
        check("zero_motor_after", 32'(motor_on), 32'd0);
        dispense_req = 1'b0;
        tick();

        // Abort after 1 of 4 portions
        portions = 3'd4;
        dispense_req = 1'b1;
        tick();
        ticks(5);
        pulse_detect();
        ticks(3);
        enable = 1'b0;
        tick();
        check("abort_motor", 32'(motor_on), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);
        check("abort_total", 32'(feed_total), 32'd6);
        enable = 1'b1;
        dispense_req = 1'b0;
        tick();

        // Cooldown: request during COOL is dropped, later one is honoured
        portions = 3'd1;
        sb.push_back(7);
        dispense_req = 1'b1;
        tick();
        pulse_detect();
        dispense_req = 1'b0;
        ticks(3);
        dispense_req = 1'b1;
        tick();
        check("cool_busy", 32'(busy), 32'd1);
        check("cool_motor", 32'(motor_on), 32'd0);
        n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        check("cool_exit", 32'(busy), 32'd0);
        check("cool_edge_dropped", 32'(motor_on), 32'd0);
        dispense_req = 1'b0;
        tick();
        sb.push_back(8);
        dispense_req = 1'b1;
        tick();
        check("cool_new_feed", 32'(motor_on), 32'd1);
        pulse_detect();
        ticks(20);

        // Reset mid-RUN with request held
        dispense_req = 1'b0;
        portions = 3'd3;
        tick();
        dispense_req = 1'b1;
        tick();
        check("prereset_motor", 32'(motor_on), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("async_motor", 32'(motor_on), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_done", 32'(done), 32'd0);
        check("async_jam", 32'(jam_fault), 32'd0);
        check("async_total", 32'(feed_total), 32'd0);
        ticks(2);
        rst = 1'b0;
        ticks(5);
        check("post_rst_no_feed", 32'(busy), 32'd0);
        check("post_rst_motor", 32'(motor_on), 32'd0);
        dispense_req = 1'b0;
        tick();
        sb.push_back(3);
        dispense_req = 1'b1;
        tick();
        check("post_rst_feed", 32'(motor_on), 32'd1);
        for (int p = 0; p < 3; p++) begin
            ticks(4);
            pulse_detect();
        end
        ticks(20);
        dispense_req = 1'b0;
        tick();

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
